// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, FSM state and address field split for the data-cache miss controller
package dcache_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int NWORDS    = 8;
    localparam int NBLOCKS   = 128;
    localparam int TAG_W     = 5;
    localparam int IDX_W     = 7;
    localparam int WRD_W     = 3;
    localparam int META_W    = 8;
    localparam int VALID_BIT = 7;

    typedef enum logic {IDLE, FILL} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [WRD_W-1:0] wrd;
    } addr_f_t;

    // Takes the halfword address (byte address without bit 0).
    function automatic addr_f_t split_addr(input logic [ADDR_W-2:0] a);
        addr_f_t f;
        f.tag = a[ADDR_W-2 -: TAG_W];
        f.idx = a[ADDR_W-2-TAG_W -: IDX_W];
        f.wrd = a[WRD_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - request, cache-array and memory signals between the controller and its surroundings
interface dcache_ctrl_if;
    import dcache_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;

    logic [DATA_W-1:0]  data_in;
    logic               data_we;
    logic [NBLOCKS-1:0] data_blockEn;
    logic [NWORDS-1:0]  wordEn;
    logic [DATA_W-1:0]  data_out;
    logic [META_W-1:0]  tag_in;
    logic               tag_we;
    logic [NBLOCKS-1:0] tag_blockEn;
    logic [META_W-1:0]  tag_out;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, data_out, tag_out, mem_rdata, mem_rvalid,
        input  rdata, stall, data_in, data_we, data_blockEn, wordEn, tag_in, tag_we, tag_blockEn,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, data_out, tag_out, mem_rdata, mem_rvalid,
        output rdata, stall, data_in, data_we, data_blockEn, wordEn, tag_in, tag_we, tag_blockEn,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - binary to one-hot decoder, N select bits to 2^N outputs
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]      i_sel,
    output logic [(1<<N)-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped, write-through/write-allocate data-cache controller with 8-word block fill
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus
);

    localparam logic [WRD_W-1:0] LAST_WRD = '1;

    state_t             r_state;
    logic [WRD_W-1:0]   r_issue_cnt;
    logic [WRD_W-1:0]   r_ret_cnt;
    logic               r_issue_done;

    addr_f_t            w_f;
    logic               w_hit;
    logic               w_last_ret;
    logic [WRD_W-1:0]   w_word_sel;
    logic [NBLOCKS-1:0] w_block_en;
    logic [NWORDS-1:0]  w_word_en;
    logic               w_unused;

    assign w_f        = split_addr(bus.req_addr[ADDR_W-1:1]);
    assign w_hit      = bus.tag_out[VALID_BIT] & (bus.tag_out[TAG_W-1:0] == w_f.tag);
    assign w_last_ret = (r_state == FILL) & bus.mem_rvalid & (r_ret_cnt == LAST_WRD);
    // During a fill the word select follows the returning data, otherwise the request.
    assign w_word_sel = (r_state == FILL) ? r_ret_cnt : w_f.wrd;
    assign w_unused   = ^{bus.req_addr[0], bus.tag_out[META_W-2:TAG_W]};

    onehot_dec #(.N(IDX_W)) u_set_dec (
        .i_sel    (w_f.idx),
        .o_onehot (w_block_en)
    );

    onehot_dec #(.N(WRD_W)) u_word_dec (
        .i_sel    (w_word_sel),
        .o_onehot (w_word_en)
    );

    assign bus.data_blockEn = w_block_en;
    assign bus.tag_blockEn  = w_block_en;
    assign bus.wordEn       = w_word_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_issue_cnt  <= '0;
            r_ret_cnt    <= '0;
            r_issue_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && !w_hit) begin
                        r_state      <= FILL;
                        r_issue_cnt  <= '0;
                        r_ret_cnt    <= '0;
                        r_issue_done <= 1'b0;
                    end
                end
                FILL: begin
                    // Separate done flag keeps the 3-bit issue counter from wrapping to word 0.
                    if (!r_issue_done) begin
                        if (r_issue_cnt == LAST_WRD) r_issue_done <= 1'b1;
                        else                         r_issue_cnt  <= r_issue_cnt + 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        r_ret_cnt <= r_ret_cnt + 1'b1;
                        if (r_ret_cnt == LAST_WRD) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded combinationally so hits cost no cycle; reset forces them all low.
    always_comb begin
        bus.stall     = 1'b0;
        bus.rdata     = '0;
        bus.data_in   = '0;
        bus.data_we   = 1'b0;
        bus.tag_in    = '0;
        bus.tag_we    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!w_hit) begin
                            bus.stall = 1'b1;
                        end else if (bus.req_we) begin
                            bus.data_we   = 1'b1;
                            bus.data_in   = bus.req_wdata;
                            bus.mem_en    = 1'b1;
                            bus.mem_wr    = 1'b1;
                            bus.mem_addr  = bus.req_addr;
                            bus.mem_wdata = bus.req_wdata;
                        end else begin
                            bus.rdata = bus.data_out;
                        end
                    end
                end
                FILL: begin
                    bus.stall = 1'b1;
                    if (!r_issue_done) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = {w_f.tag, w_f.idx, r_issue_cnt, 1'b0};
                    end
                    if (bus.mem_rvalid) begin
                        bus.data_we = 1'b1;
                        bus.data_in = bus.mem_rdata;
                    end
                    if (w_last_ret) begin
                        bus.tag_we = 1'b1;
                        bus.tag_in = {1'b1, {(META_W-TAG_W-1){1'b0}}, w_f.tag};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl with modelled arrays, 4-cycle memory and reference cache
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();
    dcache_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Environment: cache arrays and a fixed-latency memory.
    logic [15:0] data_arr    [NBLOCKS][NWORDS] = '{default: '{default: 16'h0}};
    logic [7:0]  tag_arr     [NBLOCKS] = '{default: 8'h00};
    logic [15:0] mem_model   [32768];
    logic        mem_written [32768] = '{default: 1'b0};
    logic [3:0]  p_v = '0;
    logic [14:0] p_a [4];
    logic        inj_rvalid = 1'b0;
    logic [15:0] inj_rdata = '0;
    logic [15:0] seed = 16'h5A3C;

    // Reference cache: which tag each set holds, and the expected memory image.
    logic        ref_valid [NBLOCKS] = '{default: 1'b0};
    logic [4:0]  ref_tag   [NBLOCKS] = '{default: 5'h0};
    logic [15:0] ref_st    [int];

    logic        obs_miss, obs_data_we, obs_mem_en, obs_mem_wr;
    int          obs_stall_cycles, obs_tag_we;
    logic [7:0]  obs_tag_in, obs_word_en;
    logic [15:0] obs_rdata, obs_mem_addr, obs_mem_wdata;
    logic [15:0] issued [$];

    function automatic logic [15:0] mem_init(input logic [14:0] a);
        logic [31:0] t;
        t = {17'd0, a} * 32'h9E37 + 32'h1234;
        return t[15:0] ^ t[31:16] ^ seed;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_st.exists(int'(a[15:1]))) return ref_st[int'(a[15:1])];
        return mem_init(a[15:1]);
    endfunction

    function automatic logic ref_miss(input logic [15:0] a);
        return !(ref_valid[a[10:4]] && ref_tag[a[10:4]] == a[15:11]);
    endfunction

    function automatic logic [6:0] oh_idx(input logic [127:0] v);
        for (int i = 0; i < 128; i++) if (v[i]) return 7'(i);
        return 7'd0;
    endfunction

    always_comb begin
        bus.data_out = data_arr[oh_idx(bus.data_blockEn)][3'(oh_idx({120'b0, bus.wordEn}))];
        bus.tag_out  = tag_arr[oh_idx(bus.tag_blockEn)];
    end

    always_comb begin
        bus.mem_rvalid = p_v[3] | inj_rvalid;
        if (inj_rvalid)               bus.mem_rdata = inj_rdata;
        else if (mem_written[p_a[3]]) bus.mem_rdata = mem_model[p_a[3]];
        else                          bus.mem_rdata = mem_init(p_a[3]);
    end

    always @(posedge clk) begin
        p_v    <= {p_v[2:0], bus.mem_en & ~bus.mem_wr};
        p_a[0] <= bus.mem_addr[15:1];
        p_a[1] <= p_a[0];
        p_a[2] <= p_a[1];
        p_a[3] <= p_a[2];
        if (bus.mem_en && bus.mem_wr) begin
            mem_model[bus.mem_addr[15:1]]   <= bus.mem_wdata;
            mem_written[bus.mem_addr[15:1]] <= 1'b1;
        end
        if (bus.data_we) data_arr[oh_idx(bus.data_blockEn)][3'(oh_idx({120'b0, bus.wordEn}))] <= bus.data_in;
        if (bus.tag_we)  tag_arr[oh_idx(bus.tag_blockEn)] <= bus.tag_in;
    end

    task automatic model_access(input logic we, input logic [15:0] a, input logic [15:0] wd);
        ref_valid[a[10:4]] = 1'b1;
        ref_tag[a[10:4]]   = a[15:11];
        if (we) ref_st[int'(a[15:1])] = wd;
    endtask

    // Presents one request, follows any fill, and records what the DUT did in the serving cycle.
    task automatic run_access(input logic we, input logic [15:0] a, input logic [15:0] wd);
        issued.delete();
        obs_stall_cycles = 0;
        obs_tag_we       = 0;
        obs_tag_in       = '0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        obs_miss = bus.stall;
        while (bus.stall === 1'b1 && obs_stall_cycles < 40) begin
            @(negedge clk);
            if (bus.stall === 1'b1) begin
                obs_stall_cycles++;
                if (bus.mem_en && !bus.mem_wr) issued.push_back(bus.mem_addr);
                if (bus.tag_we) begin obs_tag_we++; obs_tag_in = bus.tag_in; end
            end
        end
        obs_rdata = bus.rdata; obs_data_we = bus.data_we; obs_word_en = bus.wordEn;
        obs_mem_en = bus.mem_en; obs_mem_wr = bus.mem_wr;
        obs_mem_addr = bus.mem_addr; obs_mem_wdata = bus.mem_wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] exp_oh;
        exp_oh = '0; exp_oh[7'h23] = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h1234; bus.req_wdata = 16'hA5A5;
        repeat (2) @(negedge clk);
        checks++; if ({bus.stall, bus.data_we, bus.tag_we, bus.mem_en, bus.mem_wr} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {bus.stall, bus.data_we, bus.tag_we, bus.mem_en, bus.mem_wr}); end
        checks++; if ({bus.rdata, bus.data_in, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.rdata, bus.data_in, bus.mem_addr, bus.mem_wdata}); end
        checks++; if (bus.data_blockEn !== exp_oh) begin errors++; $display("FAIL reset_blocken got %h want %h", bus.data_blockEn, exp_oh); end
        bus.req_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", bus.stall); end
    endtask

    task automatic test_load_miss();
        logic [15:0] exp_rd;
        exp_rd = ref_rd(16'h1234);
        run_access(1'b0, 16'h1234, 16'h0);
        checks++; if (obs_miss !== 1'b1) begin errors++; $display("FAIL lm_miss got %b want 1", obs_miss); end
        checks++; if (obs_stall_cycles != 12) begin errors++; $display("FAIL lm_fill_stall got %0d want 12", obs_stall_cycles); end
        checks++; if (issued.size() != 8) begin errors++; $display("FAIL lm_issue_cnt got %0d want 8", issued.size()); end
        for (int k = 0; k < issued.size() && k < 8; k++) begin
            checks++; if (issued[k] !== 16'(16'h1230 + 2 * k)) begin errors++; $display("FAIL lm_issue_addr%0d got %h want %h", k, issued[k], 16'(16'h1230 + 2 * k)); end
        end
        checks++; if (obs_tag_we != 1 || obs_tag_in !== 8'h82) begin errors++; $display("FAIL lm_tag_in got %0d x %h want 1 x 82", obs_tag_we, obs_tag_in); end
        checks++; if (tag_arr[7'h23] !== 8'h82) begin errors++; $display("FAIL lm_tag_set got %h want 82", tag_arr[7'h23]); end
        checks++; if (obs_rdata !== exp_rd) begin errors++; $display("FAIL lm_rdata got %h want %h", obs_rdata, exp_rd); end
        checks++; if (obs_mem_en !== 1'b0) begin errors++; $display("FAIL lm_mem_en got %b want 0", obs_mem_en); end
        model_access(1'b0, 16'h1234, 16'h0);
    endtask

    task automatic test_load_hit();
        logic [15:0] exp_rd;
        exp_rd = ref_rd(16'h1236);
        run_access(1'b0, 16'h1236, 16'h0);
        checks++; if (obs_miss !== 1'b0 || obs_stall_cycles != 0) begin errors++; $display("FAIL lh_stall got %b/%0d want 0/0", obs_miss, obs_stall_cycles); end
        checks++; if (obs_rdata !== exp_rd) begin errors++; $display("FAIL lh_rdata got %h want %h", obs_rdata, exp_rd); end
        checks++; if (obs_mem_en !== 1'b0) begin errors++; $display("FAIL lh_mem_en got %b want 0", obs_mem_en); end
    endtask

    task automatic test_store_hit();
        run_access(1'b1, 16'h1230, 16'hBEEF);
        checks++; if (obs_miss !== 1'b0) begin errors++; $display("FAIL sh_stall got %b want 0", obs_miss); end
        checks++; if ({obs_data_we, obs_word_en, obs_mem_en, obs_mem_wr} !== 11'b1_00000001_1_1) begin errors++; $display("FAIL sh_enables got %b want 10000000111", {obs_data_we, obs_word_en, obs_mem_en, obs_mem_wr}); end
        checks++; if (obs_mem_addr !== 16'h1230 || obs_mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL sh_mem got %h/%h want 1230/beef", obs_mem_addr, obs_mem_wdata); end
        model_access(1'b1, 16'h1230, 16'hBEEF);
        run_access(1'b0, 16'h1230, 16'h0);
        checks++; if (obs_miss !== 1'b0 || obs_rdata !== 16'hBEEF) begin errors++; $display("FAIL sh_readback got %b/%h want 0/beef", obs_miss, obs_rdata); end
    endtask

    task automatic test_store_conflict();
        logic [15:0] wd;
        wd = 16'($urandom);
        run_access(1'b1, 16'h9A30, wd);
        checks++; if (obs_miss !== 1'b1 || obs_stall_cycles != 12) begin errors++; $display("FAIL sc_fill got %b/%0d want 1/12", obs_miss, obs_stall_cycles); end
        checks++; if (obs_tag_in !== 8'h93 || tag_arr[7'h23] !== 8'h93) begin errors++; $display("FAIL sc_tag got %h/%h want 93/93", obs_tag_in, tag_arr[7'h23]); end
        checks++; if ({obs_data_we, obs_mem_en, obs_mem_wr} !== 3'b111 || obs_mem_addr !== 16'h9A30 || obs_mem_wdata !== wd) begin errors++; $display("FAIL sc_store got %b %h %h want 111 9a30 %h", {obs_data_we, obs_mem_en, obs_mem_wr}, obs_mem_addr, obs_mem_wdata, wd); end
        model_access(1'b1, 16'h9A30, wd);
        run_access(1'b0, 16'h9A30, 16'h0);
        checks++; if (obs_miss !== 1'b0 || obs_rdata !== wd) begin errors++; $display("FAIL sc_readback got %b/%h want 0/%h", obs_miss, obs_rdata, wd); end
        run_access(1'b0, 16'h1230, 16'h0);
        checks++; if (obs_miss !== 1'b1 || obs_rdata !== 16'hBEEF) begin errors++; $display("FAIL sc_old_evicted got %b/%h want 1/beef", obs_miss, obs_rdata); end
        model_access(1'b0, 16'h1230, 16'h0);
    endtask

    task automatic test_reset_in_fill();
        int n_we, n_tag, n_stall;
        logic [15:0] exp_rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h5554;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rf_in_fill got %b want 1", bus.stall); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({bus.stall, bus.data_we, bus.tag_we, bus.mem_en, bus.mem_wr} !== 5'b0 || bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rf_async got %b %h want 00000 0000", {bus.stall, bus.data_we, bus.tag_we, bus.mem_en, bus.mem_wr}, bus.mem_addr); end
        bus.req_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        n_we = 0; n_tag = 0; n_stall = 0;
        repeat (12) begin
            @(negedge clk);
            n_we += int'(bus.data_we); n_tag += int'(bus.tag_we); n_stall += int'(bus.stall);
        end
        checks++; if (n_we != 0 || n_tag != 0 || n_stall != 0) begin errors++; $display("FAIL rf_late_rvalid got we=%0d tag=%0d stall=%0d want 0", n_we, n_tag, n_stall); end
        checks++; if (tag_arr[7'h55][7] !== 1'b0) begin errors++; $display("FAIL rf_set_invalid got %h want valid bit 0", tag_arr[7'h55]); end
        exp_rd = ref_rd(16'h5554);
        run_access(1'b0, 16'h5554, 16'h0);
        checks++; if (obs_miss !== 1'b1 || obs_stall_cycles != 12 || obs_rdata !== exp_rd) begin errors++; $display("FAIL rf_reload got %b/%0d/%h want 1/12/%h", obs_miss, obs_stall_cycles, obs_rdata, exp_rd); end
        model_access(1'b0, 16'h5554, 16'h0);
    endtask

    task automatic test_idle_rvalid();
        int n_we, n_tag, n_stall, n_en;
        n_we = 0; n_tag = 0; n_stall = 0; n_en = 0;
        repeat (40) begin
            @(posedge clk); #1;
            inj_rvalid = 1'($urandom_range(0, 1));
            inj_rdata  = 16'($urandom);
            bus.req_addr = 16'($urandom);
            @(negedge clk);
            n_we += int'(bus.data_we); n_tag += int'(bus.tag_we);
            n_stall += int'(bus.stall); n_en += int'(bus.mem_en);
        end
        @(posedge clk); #1 inj_rvalid = 1'b0;
        checks++; if (n_we != 0 || n_tag != 0) begin errors++; $display("FAIL ir_writes got we=%0d tag=%0d want 0", n_we, n_tag); end
        checks++; if (n_stall != 0 || n_en != 0) begin errors++; $display("FAIL ir_stall got stall=%0d mem_en=%0d want 0", n_stall, n_en); end
    endtask

    task automatic test_random();
        logic [4:0]  tags [4] = '{5'h02, 5'h13, 5'h07, 5'h1F};
        logic [6:0]  idxs [3] = '{7'h23, 7'h10, 7'h7F};
        logic [15:0] a, wd, exp_rd;
        logic        we, miss;
        for (int n = 0; n < 40; n++) begin
            a  = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 2)], 3'($urandom), 1'b0};
            we = 1'($urandom);
            wd = 16'($urandom);
            miss   = ref_miss(a);
            exp_rd = ref_rd(a);
            run_access(we, a, wd);
            checks++; if (obs_miss !== miss || obs_stall_cycles != (miss ? 12 : 0)) begin errors++; $display("FAIL rnd%0d_miss a=%h got %b/%0d want %b/%0d", n, a, obs_miss, obs_stall_cycles, miss, miss ? 12 : 0); end
            if (miss) begin
                checks++; if (obs_tag_we != 1 || obs_tag_in !== {3'b100, a[15:11]}) begin errors++; $display("FAIL rnd%0d_tag got %0d x %h want 1 x %h", n, obs_tag_we, obs_tag_in, {3'b100, a[15:11]}); end
            end
            if (we) begin
                checks++; if ({obs_data_we, obs_mem_en, obs_mem_wr} !== 3'b111 || obs_mem_addr !== a || obs_mem_wdata !== wd) begin errors++; $display("FAIL rnd%0d_store got %b %h %h want 111 %h %h", n, {obs_data_we, obs_mem_en, obs_mem_wr}, obs_mem_addr, obs_mem_wdata, a, wd); end
            end else begin
                checks++; if (obs_rdata !== exp_rd || obs_mem_en !== 1'b0) begin errors++; $display("FAIL rnd%0d_load a=%h got %h/%b want %h/0", n, a, obs_rdata, obs_mem_en, exp_rd); end
            end
            model_access(we, a, wd);
        end
    endtask

    initial begin
        seed = 16'($urandom);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_conflict();
        test_reset_in_fill();
        test_idle_rvalid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
